// File: rtl/instr_reg_assembler.sv
// Fetch-path instruction register: collects BEATS bus beats into one instruction word,
// then exposes it split into opcode and operand-address fields.
module instr_reg_assembler #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BEATS     = 2,
  parameter int unsigned OPC_W     = 3,
  parameter bit          OPC_LSB   = 1'b1,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned INSTR_W  = DATA_W * BEATS,
  localparam int unsigned ADDR_W   = INSTR_W - OPC_W
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic [DATA_W-1:0]  r_data,
  input  logic               r_ena,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr,
  output logic [OPC_W-1:0]   opcode1,
  output logic [ADDR_W-1:0]  ir_addr1,
  output logic               ir_valid,
  output logic               busy,
  output logic               frag_err
);

  localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  if (BEATS < 1) begin : g_bad_beats
    $error("instr_reg_assembler: BEATS must be at least 1");
  end
  if (OPC_W < 1 || OPC_W > INSTR_W - 1) begin : g_bad_opc
    $error("instr_reg_assembler: OPC_W must lie in 1..INSTR_W-1");
  end

  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               frag_q, frag_d;

  // Bit position of the least significant bit of beat slot k.
  function automatic int unsigned slot_lsb(input logic [CntW-1:0] k);
    if (MSB_FIRST) begin
      return INSTR_W - (32'(k) + 32'd1) * DATA_W;
    end
    return 32'(k) * DATA_W;
  endfunction

  always_comb begin
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    frag_d  = 1'b0;
    if (flush) begin
      cnt_d = '0;
    end else if (r_ena) begin
      buf_d[slot_lsb(cnt_q) +: DATA_W] = r_data;
      if (cnt_q == LastCnt) begin
        // Last beat merges into the word in the same edge, so no bubble between instructions.
        instr_d = buf_d;
        cnt_d   = '0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d  = '0;
      frag_d = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      frag_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      frag_q  <= frag_d;
    end
  end

  assign instr    = instr_q;
  assign ir_valid = valid_q;
  assign frag_err = frag_q;
  assign busy     = (cnt_q != '0);

  if (OPC_LSB) begin : g_opc_low
    assign opcode1  = instr_q[OPC_W-1:0];
    assign ir_addr1 = instr_q[INSTR_W-1:OPC_W];
  end else begin : g_opc_high
    assign opcode1  = instr_q[INSTR_W-1 -: OPC_W];
    assign ir_addr1 = instr_q[ADDR_W-1:0];
  end

endmodule

// File: tb/tb_instr_reg_assembler.sv
// Bench for instr_reg_assembler: a default 2-beat instance and a 4-beat LSB-first instance,
// each checked every cycle against a queue-based model, plus directed literal checks.
module tb_instr_reg_assembler;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic rst;
  logic [7:0] a_data, b_data;
  logic a_ena, a_flush, b_ena, b_flush;

  logic [15:0] a_instr;
  logic [2:0]  a_opc;
  logic [12:0] a_addr;
  logic        a_valid, a_busy, a_frag;

  logic [31:0] b_instr;
  logic [4:0]  b_opc;
  logic [26:0] b_addr;
  logic        b_valid, b_busy, b_frag;

  instr_reg_assembler u_a (
    .clk1    (clk1),
    .rst     (rst),
    .r_data  (a_data),
    .r_ena   (a_ena),
    .flush   (a_flush),
    .instr   (a_instr),
    .opcode1 (a_opc),
    .ir_addr1(a_addr),
    .ir_valid(a_valid),
    .busy    (a_busy),
    .frag_err(a_frag)
  );

  instr_reg_assembler #(
    .DATA_W   (8),
    .BEATS    (4),
    .OPC_W    (5),
    .OPC_LSB  (1'b0),
    .MSB_FIRST(1'b0)
  ) u_b (
    .clk1    (clk1),
    .rst     (rst),
    .r_data  (b_data),
    .r_ena   (b_ena),
    .flush   (b_flush),
    .instr   (b_instr),
    .opcode1 (b_opc),
    .ir_addr1(b_addr),
    .ir_valid(b_valid),
    .busy    (b_busy),
    .frag_err(b_frag)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Beat k in queue order; MSB-first shifts earlier beats up, LSB-first places beat k at k*8.
  function automatic logic [63:0] assemble(input logic [7:0] q[$], input bit msb_first);
    logic [63:0] w = 64'd0;
    for (int k = 0; k < q.size(); k++) begin
      if (msb_first) w = (w << 8) | 64'(q[k]);
      else           w = w | (64'(q[k]) << (8 * k));
    end
    return w;
  endfunction

  logic [7:0]  ma_q[$];
  logic [7:0]  mb_q[$];
  logic [63:0] ma_instr, mb_instr;
  bit          ma_valid, ma_frag, mb_valid, mb_frag;

  initial begin
    forever begin
      @(posedge clk1 or negedge rst);
      ma_valid = 1'b0; ma_frag = 1'b0; mb_valid = 1'b0; mb_frag = 1'b0;
      if (!rst) begin
        ma_q.delete(); mb_q.delete();
        ma_instr = 64'd0; mb_instr = 64'd0;
      end else begin
        if (a_flush) ma_q.delete();
        else if (a_ena) begin
          ma_q.push_back(a_data);
          if (ma_q.size() == 2) begin
            ma_instr = assemble(ma_q, 1'b1); ma_valid = 1'b1; ma_q.delete();
          end
        end else if (ma_q.size() != 0) begin
          ma_q.delete(); ma_frag = 1'b1;
        end
        if (b_flush) mb_q.delete();
        else if (b_ena) begin
          mb_q.push_back(b_data);
          if (mb_q.size() == 4) begin
            mb_instr = assemble(mb_q, 1'b0); mb_valid = 1'b1; mb_q.delete();
          end
        end else if (mb_q.size() != 0) begin
          mb_q.delete(); mb_frag = 1'b1;
        end
      end
    end
  end

  always @(negedge clk1) begin
    if (chk_en) begin
      check("a_instr", 64'(a_instr), ma_instr);
      check("a_opcode", 64'(a_opc), ma_instr % 64'd8);
      check("a_addr", 64'(a_addr), ma_instr >> 3);
      check("a_valid", 64'(a_valid), 64'(ma_valid));
      check("a_busy", 64'(a_busy), 64'(ma_q.size() != 0));
      check("a_frag", 64'(a_frag), 64'(ma_frag));
      check("b_instr", 64'(b_instr), mb_instr);
      check("b_opcode", 64'(b_opc), mb_instr >> 27);
      check("b_addr", 64'(b_addr), mb_instr % (64'd1 << 27));
      check("b_valid", 64'(b_valid), 64'(mb_valid));
      check("b_busy", 64'(b_busy), 64'(mb_q.size() != 0));
      check("b_frag", 64'(b_frag), 64'(mb_frag));
    end
  end

  // Inputs change just after a falling edge and are held across the next rising edge.
  task automatic drv_a(input bit ena, input logic [7:0] d, input bit fl);
    a_ena = ena; a_data = d; a_flush = fl;
    b_ena = 1'b0; b_flush = 1'b0;
    @(negedge clk1);
  endtask

  task automatic drv_b(input bit ena, input logic [7:0] d);
    b_ena = ena; b_data = d; b_flush = 1'b0;
    a_ena = 1'b0; a_flush = 1'b0;
    @(negedge clk1);
  endtask

  initial begin
    rst = 1'b0;
    a_ena = 1'b0; a_data = 8'h00; a_flush = 1'b0;
    b_ena = 1'b0; b_data = 8'h00; b_flush = 1'b0;
    repeat (2) @(negedge clk1);
    check("reset_instr", 64'(a_instr), 64'd0);
    check("reset_busy", 64'(a_busy), 64'd0);
    check("reset_b_instr", 64'(b_instr), 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk1);

    // Default two-beat fetch
    drv_a(1, 8'hA5, 0);
    check("dflt_busy_mid", 64'(a_busy), 64'd1);
    drv_a(1, 8'h3C, 0);
    check("dflt_instr", 64'(a_instr), 64'hA53C);
    check("dflt_opc", 64'(a_opc), 64'd4);
    check("dflt_addr", 64'(a_addr), 64'h14A7);
    check("dflt_valid", 64'(a_valid), 64'd1);
    check("dflt_busy_end", 64'(a_busy), 64'd0);
    drv_a(0, 8'h00, 0);
    check("dflt_valid_drop", 64'(a_valid), 64'd0);

    // Fragment
    drv_a(1, 8'h12, 0);
    drv_a(0, 8'h00, 0);
    check("frag_err", 64'(a_frag), 64'd1);
    check("frag_busy", 64'(a_busy), 64'd0);
    check("frag_instr", 64'(a_instr), 64'hA53C);
    check("frag_valid", 64'(a_valid), 64'd0);
    drv_a(0, 8'h00, 0);
    check("frag_pulse", 64'(a_frag), 64'd0);

    // Back-to-back
    drv_a(1, 8'h11, 0);
    drv_a(1, 8'h22, 0);
    check("b2b_first", 64'(a_instr), 64'h1122);
    check("b2b_v1", 64'(a_valid), 64'd1);
    drv_a(1, 8'h33, 0);
    check("b2b_gap", 64'(a_valid), 64'd0);
    drv_a(1, 8'h44, 0);
    check("b2b_second", 64'(a_instr), 64'h3344);
    check("b2b_v2", 64'(a_valid), 64'd1);

    // Flush priority
    drv_a(1, 8'h55, 0);
    drv_a(1, 8'h66, 1);
    check("flush_busy", 64'(a_busy), 64'd0);
    check("flush_valid", 64'(a_valid), 64'd0);
    check("flush_frag", 64'(a_frag), 64'd0);
    check("flush_instr", 64'(a_instr), 64'h3344);
    drv_a(1, 8'h77, 0);
    drv_a(1, 8'h88, 0);
    check("flush_after", 64'(a_instr), 64'h7788);

    // Asynchronous reset mid-instruction
    drv_a(1, 8'h99, 0);
    a_ena = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_instr", 64'(a_instr), 64'd0);
    check("arst_busy", 64'(a_busy), 64'd0);
    check("arst_opc", 64'(a_opc), 64'd0);
    check("arst_addr", 64'(a_addr), 64'd0);
    @(negedge clk1);
    rst = 1'b1;
    drv_a(1, 8'hFF, 0);
    drv_a(1, 8'h01, 0);
    check("arst_after", 64'(a_instr), 64'hFF01);
    check("arst_after_opc", 64'(a_opc), 64'd1);
    check("arst_after_addr", 64'(a_addr), 64'h1FE0);

    // Four-beat, LSB-first, opcode-high instance
    drv_b(1, 8'h78);
    drv_b(1, 8'h56);
    drv_b(1, 8'h34);
    check("cfg_no_early_valid", 64'(b_valid), 64'd0);
    drv_b(1, 8'hF2);
    check("cfg_instr", 64'(b_instr), 64'hF2345678);
    check("cfg_opc", 64'(b_opc), 64'h1E);
    check("cfg_addr", 64'(b_addr), 64'h2345678);
    check("cfg_valid", 64'(b_valid), 64'd1);
    drv_b(0, 8'h00);
    check("cfg_valid_drop", 64'(b_valid), 64'd0);

    // Randomised traffic on both instances
    for (int i = 0; i < 1500; i++) begin
      a_ena   = ($urandom_range(0, 9) < 8);
      a_flush = ($urandom_range(0, 24) == 0);
      a_data  = 8'($urandom);
      b_ena   = ($urandom_range(0, 19) < 18);
      b_flush = ($urandom_range(0, 29) == 0);
      b_data  = 8'($urandom);
      if (i == 700) begin
        #3 rst = 1'b0;
        @(negedge clk1);
        rst = 1'b1;
      end else begin
        @(negedge clk1);
      end
    end
    a_ena = 1'b0; b_ena = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
    repeat (2) @(negedge clk1);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_reg_assembler.md
Name: instr_reg_assembler

Overview:
- Parametrised instruction register for the RISC CPU fetch path.
- Assembles one instruction of BEATS × DATA_W bits from successive beats on the memory data bus, gated by r_ena.
- Splits the completed instruction into opcode and operand-address fields, with configurable field placement and beat order.
- Updates only on a complete instruction, reports completion, and flags fragmented fetches.

Parameters:
DATA_W, 8, width of one bus beat
BEATS, 2, beats per instruction (>=1); INSTR_W = DATA_W*BEATS
OPC_W, 3, opcode width (1..INSTR_W-1); ADDR_W = INSTR_W-OPC_W
OPC_LSB, 1, 1: opcode = instr[OPC_W-1:0], addr = instr[INSTR_W-1:OPC_W]; 0: opcode = instr[INSTR_W-1 -: OPC_W], addr = instr[ADDR_W-1:0]
MSB_FIRST, 1, 1: beat k fills instr[INSTR_W-1-k*DATA_W -: DATA_W]; 0: beat k fills instr[k*DATA_W +: DATA_W]

Ports:
clk1  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
r_data  input  DATA_W  instruction beat from memory bus
r_ena  input  1  beat valid; sampled every rising clk1 edge
flush  input  1  synchronous discard of the partial instruction; high priority
instr  output  INSTR_W  last completed instruction
opcode1  output  OPC_W  opcode field of instr
ir_addr1  output  ADDR_W  address field of instr
ir_valid  output  1  one-cycle pulse: instr updated at the preceding edge
busy  output  1  partial instruction held (beat counter != 0)
frag_err  output  1  one-cycle pulse: partial instruction dropped by r_ena low

Behaviour:
- Reset (rst=0, asynchronous): beat counter=0, assembly buffer=0, instr=0, ir_valid=0, frag_err=0. As a result, busy=0, opcode1=0 and ir_addr1=0.
- Reset release: registers leave reset on the first rising clk1 edge after rst goes high.
- Beat counter: cnt ranges 0..BEATS-1, width $clog2(BEATS) with a minimum of 1. busy = (cnt != 0).
- Per-edge priority: flush > r_ena > idle.
- flush=1: cnt<=0 and the buffer contents are ignored. instr is unchanged. ir_valid=0 and frag_err=0, even if r_ena=1 or a partial instruction is held.
- r_ena=1, cnt<BEATS-1: r_data is written into slot cnt of the buffer; cnt<=cnt+1.
- r_ena=1, cnt=BEATS-1 (last beat):
  - instr <= buffer with r_data merged into the last slot, in the same edge.
  - cnt<=0, and ir_valid=1 for the following cycle.
  - Latency: opcode1/ir_addr1 are valid in the cycle after the last-beat edge.
- r_ena=0, cnt!=0: cnt<=0 and the partial instruction is discarded. frag_err=1 for one cycle; instr is unchanged.
- r_ena=0, cnt=0: no change.
- Back-to-back instructions: continuous r_ena is legal. A new instruction starts on the beat after the last beat, with no bubble. ir_valid may be asserted every BEATS cycles.
- BEATS=1: every r_ena=1 edge loads instr directly. busy and frag_err are constantly 0.
- Outputs are purely registered or derived by wiring from registers (opcode1/ir_addr1 are slices of instr). No combinational path from inputs to outputs.
- Unused buffer slots keep stale data. This is harmless because every slot is rewritten before each completion.
- Illegal parameters (BEATS<1, OPC_W outside 1..INSTR_W-1) are rejected at elaboration.

Test Plan:
- Defaults. Reset, then beats r_ena=1 with 0xA5, 0x3C on consecutive edges -> next cycle: instr=0xA53C, opcode1=3'd4, ir_addr1=13'h14A7, ir_valid high exactly 1 cycle, busy=1 only between the beats.
- Fragment. After the case above, beat 0x12 then r_ena=0 -> frag_err pulses 1 cycle, busy returns to 0, instr stays 0xA53C, no ir_valid.
- Back-to-back. Continuous r_ena with 0x11, 0x22, 0x33, 0x44 -> ir_valid pulses twice, 2 cycles apart; instr becomes 0x1122, then 0x3344.
- Flush priority. Beat 0x55, then flush=1 with r_ena=1 and r_data=0x66 -> cnt=0, no ir_valid, no frag_err, instr unchanged. Then 0x77, 0x88 -> instr=0x7788.
- Async reset mid-instruction. After one beat, drive rst=0 between edges -> all outputs are 0 immediately. After release, 0xFF, 0x01 -> instr=0xFF01, opcode1=1, ir_addr1=13'h1FE0.
- Config DATA_W=8, BEATS=4, OPC_W=5, OPC_LSB=0, MSB_FIRST=0. Beats 0x78, 0x56, 0x34, 0xF2 -> instr=0xF2345678, opcode1=5'h1E, ir_addr1=27'h2345678, single ir_valid.
